alu_rol_7bit_seq: RTL

- Sequential rotate-left unit for the 7-bit ALU datapath; the opposite direction to the existing combinational rotate-right.
- Rotates the captured operand left by one position per clock until the requested amount is consumed.
- Uses valid/ready handshakes on input and output, so the ALU sequencer can stall either side.
- Rotate-left by k equals rotate-right by (7-k) mod 7; the bench uses this identity as a cross-check.

---
 rtl/alu_rol_7bit_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/alu_rol_7bit_seq.sv
// alu_rol_7bit_seq: sequential rotate-left unit for the 7-bit ALU datapath.
// Rotates the captured operand one position per clock, with valid/ready on both sides.
module alu_rol_7bit_seq #(
    parameter int WIDTH = 7,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_rot;
    logic [SHW-1:0]   count;
    logic [SHW-1:0]   amount;
    logic             accept;
    logic             last_rot;

    // A full-width rotate is the identity, so the amount is reduced modulo WIDTH.
    assign amount   = SHW'(32'(shift) % WIDTH);
    assign data_rot = {data[WIDTH-2:0], data[WIDTH-1]};
    assign accept   = (state == IDLE) && in_valid;
    assign last_rot = (state == ROTATE) && (count == SHW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (amount == '0) ? DONE : ROTATE;
                end
            end
            ROTATE: begin
                busy = 1'b1;
                if (count == SHW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // out is loaded only on the edge that enters DONE, so it never shows
    // intermediate rotations and holds its value after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            count <= '0;
            out   <= '0;
        end else if (accept) begin
            data  <= in;
            count <= amount;
            if (amount == '0) begin
                out <= in;
            end
        end else if (state == ROTATE) begin
            data  <= data_rot;
            count <= count - SHW'(1);
            if (last_rot) begin
                out <= data_rot;
            end
        end
    end

endmodule
